// File: rtl/spi_slave.sv
// SPI slave for CPHA=0 links (mode 0 / mode 2): pins are oversampled in the clk domain,
// MOSI words are deserialised with their D/C flag and a preloaded response is shifted out on MISO.
module spi_slave #(
    parameter int CPOL        = 0,
    parameter int DATA_WIDTH  = 8,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  ncs_pin,
    input  logic                  clk_pin,
    input  logic                  mosi_pin,
    input  logic                  dc_pin,
    output logic                  miso_pin,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_dc,
    output logic                  rx_valid,
    output logic                  spi_busy,
    output logic                  state_dbg
);

    localparam int   CW        = $clog2(DATA_WIDTH + 1);
    localparam logic SCLK_IDLE = (CPOL != 0);

    typedef enum logic {S_IDLE, S_SHIFT} state_e;

    // TX handshake: tx_load is taken only while tx_ready (holding register empty) is high;
    // tx_ready falls the cycle after acceptance and rises the cycle after the shifter takes the word.

    logic [SYNC_STAGES-1:0] ncs_sync_q, sclk_sync_q, mosi_sync_q, dc_sync_q;
    logic                   ncs_s, sclk_s, mosi_s, dc_s;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ncs_sync_q  <= '1;
            sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
            mosi_sync_q <= '0;
            dc_sync_q   <= '0;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_pin};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], clk_pin};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_pin};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], dc_pin};
        end
    end

    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign dc_s   = dc_sync_q[SYNC_STAGES-1];

    // Edge flags are registered; data and D/C are registered alongside so they stay aligned.
    logic ncs_prev_q, sclk_prev_q;
    logic ncs_fall_q, ncs_rise_q, lead_q, trail_q, mosi_smp_q, dc_smp_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ncs_prev_q  <= 1'b1;
            sclk_prev_q <= SCLK_IDLE;
            ncs_fall_q  <= 1'b0;
            ncs_rise_q  <= 1'b0;
            lead_q      <= 1'b0;
            trail_q     <= 1'b0;
            mosi_smp_q  <= 1'b0;
            dc_smp_q    <= 1'b0;
        end else begin
            ncs_prev_q  <= ncs_s;
            sclk_prev_q <= sclk_s;
            ncs_fall_q  <= ncs_prev_q & ~ncs_s;
            ncs_rise_q  <= ~ncs_prev_q & ncs_s;
            lead_q      <= (sclk_prev_q != sclk_s) && (sclk_s != SCLK_IDLE);
            trail_q     <= (sclk_prev_q != sclk_s) && (sclk_s == SCLK_IDLE);
            mosi_smp_q  <= mosi_s;
            dc_smp_q    <= dc_s;
        end
    end

    function automatic logic wire_bit(input logic [DATA_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
    endfunction

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d, hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  rx_dc_q, rx_dc_d, rx_valid_q, rx_valid_d;
    logic                  miso_q, miso_d, oe_q, oe_d, underrun_q, underrun_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  reload;
    logic [DATA_WIDTH-1:0] reload_word, rx_shifted, tx_shifted;

    always_comb begin
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_data_d   = rx_data_q;
        rx_dc_d     = rx_dc_q;
        rx_valid_d  = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        underrun_d  = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        reload      = 1'b0;
        reload_word = '0;

        rx_shifted = (MSB_FIRST != 0) ? {rx_sr_q[DATA_WIDTH-2:0], mosi_smp_q}
                                      : {mosi_smp_q, rx_sr_q[DATA_WIDTH-1:1]};
        tx_shifted = (MSB_FIRST != 0) ? {tx_sr_q[DATA_WIDTH-2:0], 1'b0}
                                      : {1'b0, tx_sr_q[DATA_WIDTH-1:1]};

        case (state_q)
            S_IDLE: begin
                if (ncs_fall_q) begin
                    reload    = 1'b1;
                    oe_d      = 1'b1;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A chip-select release outranks a coincident sampling edge.
                if (ncs_rise_q) begin
                    state_d   = S_IDLE;
                    oe_d      = 1'b0;
                    miso_d    = 1'b0;
                    bit_cnt_d = '0;
                end else if (lead_q) begin
                    rx_sr_d = rx_shifted;
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        rx_data_d  = rx_shifted;
                        rx_dc_d    = dc_smp_q;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (trail_q) begin
                    if (bit_cnt_q != '0) begin
                        tx_sr_d = tx_shifted;
                        miso_d  = wire_bit(tx_shifted);
                    end else begin
                        reload = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Empty holding register at reload time: a same-cycle tx_load bypasses straight in.
        if (reload) begin
            if (hold_full_q) begin
                reload_word = hold_q;
                hold_full_d = 1'b0;
            end else if (tx_load) begin
                reload_word = tx_data;
            end else begin
                underrun_d = 1'b1;
            end
            tx_sr_d = reload_word;
            miso_d  = wire_bit(reload_word);
        end else if (tx_load && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
            rx_dc_q     <= 1'b0;
            rx_valid_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            underrun_q  <= 1'b0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_dc_q     <= rx_dc_d;
            rx_valid_q  <= rx_valid_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            underrun_q  <= underrun_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign miso_pin    = miso_q;
    assign miso_oe     = oe_q;
    assign tx_ready    = ~hold_full_q;
    assign tx_underrun = underrun_q;
    assign rx_data     = rx_data_q;
    assign rx_dc       = rx_dc_q;
    assign rx_valid    = rx_valid_q;
    assign spi_busy    = ~ncs_s;
    assign state_dbg   = (state_q == S_SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one bus master drives a mode-0/MSB-first slave and a mode-2/LSB-first
// slave in parallel (the mode-2 clock is the inverted mode-0 clock).
module tb_spi_slave;

    localparam int W    = 8;
    localparam int HALF = 6;

    logic         clk = 1'b0;
    logic         arst = 1'b1;
    logic         ncs_pin = 1'b1;
    logic         sclk0 = 1'b0;
    logic         sclk1;
    logic         mosi = 1'b0;
    logic         dc = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_load = 1'b0;

    logic         miso0, oe0, rdy0, und0, rxdc0, rxv0, busy0, st0;
    logic         miso1, oe1, rdy1, und1, rxdc1, rxv1, busy1, st1;
    logic [W-1:0] rxd0, rxd1;
    logic [W+6:0] outs0, outs1;

    localparam logic [W+6:0] RST_OUTS = {1'b0, 1'b0, 1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b0};

    int checks = 0;
    int failures = 0;

    logic [W:0] got0_q[$];
    logic [W:0] got1_q[$];
    int         und0_cnt = 0;
    int         und1_cnt = 0;

    assign sclk1 = ~sclk0;
    assign outs0 = {miso0, oe0, rdy0, und0, rxd0, rxdc0, rxv0, busy0};
    assign outs1 = {miso1, oe1, rdy1, und1, rxd1, rxdc1, rxv1, busy1};

    always #5 clk = ~clk;

    spi_slave #(.CPOL(0), .DATA_WIDTH(W), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .arst(arst), .ncs_pin(ncs_pin), .clk_pin(sclk0), .mosi_pin(mosi),
        .dc_pin(dc), .miso_pin(miso0), .miso_oe(oe0), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(rdy0), .tx_underrun(und0), .rx_data(rxd0), .rx_dc(rxdc0),
        .rx_valid(rxv0), .spi_busy(busy0), .state_dbg(st0)
    );

    spi_slave #(.CPOL(1), .DATA_WIDTH(W), .MSB_FIRST(0), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .arst(arst), .ncs_pin(ncs_pin), .clk_pin(sclk1), .mosi_pin(mosi),
        .dc_pin(dc), .miso_pin(miso1), .miso_oe(oe1), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(rdy1), .tx_underrun(und1), .rx_data(rxd1), .rx_dc(rxdc1),
        .rx_valid(rxv1), .spi_busy(busy1), .state_dbg(st1)
    );

    // Received words and underrun pulses as seen by the system side.
    always @(negedge clk) begin
        if (rxv0) got0_q.push_back({rxdc0, rxd0});
        if (rxv1) got1_q.push_back({rxdc1, rxd1});
        if (und0) und0_cnt++;
        if (und1) und1_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    // ---------------- driver tasks (each starts and ends just after a clk negedge) ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        got0_q.delete();
        got1_q.delete();
        und0_cnt = 0;
        und1_cnt = 0;
    endtask

    task automatic load_word(input logic [W-1:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        tx_data = '0;
    endtask

    task automatic cs_low();
        ncs_pin = 1'b0;
        wait_clk(HALF);
    endtask

    // One bit: trailing edge (if the clock is active) with new data, then the leading edge.
    task automatic spi_bit(input logic b, input logic d, output logic m0, output logic m1);
        if (sclk0) sclk0 = 1'b0;
        mosi = b;
        dc   = d;
        wait_clk(HALF);
        m0 = miso0;
        m1 = miso1;
        sclk0 = 1'b1;
        wait_clk(HALF);
    endtask

    // Chip select rises while the clock is still active; the clock returns to idle afterwards.
    task automatic cs_high();
        ncs_pin = 1'b1;
        wait_clk(3);
        sclk0 = 1'b0;
        mosi  = 1'b0;
        dc    = 1'b0;
        wait_clk(HALF + 2);
    endtask

    task automatic xfer_word(input logic [W-1:0] wv, input logic d, input logic do_load,
                             input logic [W-1:0] lv, output logic [W-1:0] r0, output logic [W-1:0] r1);
        logic m0, m1;
        r0 = '0;
        r1 = '0;
        for (int i = W - 1; i >= 0; i--) begin
            spi_bit(wv[i], d, m0, m1);
            r0[i] = m0;
            r1[i] = m1;
            if (do_load && i == 4) load_word(lv);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        wait_clk(3);
        checks++;
        if (outs0 !== RST_OUTS) begin
            failures++;
            $display("FAIL reset_outs0: got %h expected %h", outs0, RST_OUTS);
        end
        checks++;
        if (outs1 !== RST_OUTS) begin
            failures++;
            $display("FAIL reset_outs1: got %h expected %h", outs1, RST_OUTS);
        end
        arst = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_single();
        logic [W-1:0] r0, r1;
        clear_obs();
        cs_low();
        checks++;
        if ({busy0, oe0, st0, busy1, oe1, st1} !== 6'b111_111) begin
            failures++;
            $display("FAIL single_busy_oe: got %b expected 111111", {busy0, oe0, st0, busy1, oe1, st1});
        end
        xfer_word(8'hA5, 1'b1, 1'b0, '0, r0, r1);
        cs_high();
        checks++;
        if (got0_q.size() != 1 || got0_q[0] !== {1'b1, 8'hA5}) begin
            failures++;
            $display("FAIL single_rx0: n=%0d got %h expected 1a5", got0_q.size(), got0_q.size() ? got0_q[0] : 9'h0);
        end
        checks++;
        if (got1_q.size() != 1 || got1_q[0] !== {1'b1, rev(8'hA5)}) begin
            failures++;
            $display("FAIL single_rx1: n=%0d got %h expected %h", got1_q.size(), got1_q.size() ? got1_q[0] : 9'h0, {1'b1, rev(8'hA5)});
        end
        checks++;
        if (und0_cnt != 1 || und1_cnt != 1) begin
            failures++;
            $display("FAIL single_underrun: got %0d/%0d expected 1/1", und0_cnt, und1_cnt);
        end
        checks++;
        if (r0 !== 8'h00 || r1 !== 8'h00) begin
            failures++;
            $display("FAIL single_miso: got %h/%h expected 00/00", r0, r1);
        end
    endtask

    task automatic test_preload();
        logic [W-1:0] r0, r1;
        clear_obs();
        load_word(8'h3C);
        checks++;
        if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
            failures++;
            $display("FAIL preload_ready_drop: got %b%b expected 00", rdy0, rdy1);
        end
        load_word(8'hEE);
        cs_low();
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL preload_ready_rise: got %b%b expected 11", rdy0, rdy1);
        end
        xfer_word(8'h5A, 1'b0, 1'b0, '0, r0, r1);
        cs_high();
        checks++;
        if (r0 !== 8'h3C || r1 !== rev(8'h3C)) begin
            failures++;
            $display("FAIL preload_miso: got %h/%h expected 3c/%h", r0, r1, rev(8'h3C));
        end
        checks++;
        if (got0_q.size() != 1 || got0_q[0] !== {1'b0, 8'h5A} || got1_q.size() != 1 || got1_q[0] !== {1'b0, rev(8'h5A)}) begin
            failures++;
            $display("FAIL preload_rx: n=%0d/%0d got %h expected 05a", got0_q.size(), got1_q.size(), got0_q.size() ? got0_q[0] : 9'h0);
        end
        checks++;
        if (und0_cnt != 0 || und1_cnt != 0) begin
            failures++;
            $display("FAIL preload_underrun: got %0d/%0d expected 0/0", und0_cnt, und1_cnt);
        end
    endtask

    task automatic test_burst();
        logic [W-1:0] r0, r1;
        logic [W-1:0] wv[3] = '{8'h11, 8'h22, 8'h33};
        logic [W-1:0] rs[3] = '{8'hC3, 8'h00, 8'h00};
        logic         dv[3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] t;
        clear_obs();
        load_word(8'hC3);
        cs_low();
        for (int k = 0; k < 3; k++) begin
            xfer_word(wv[k], dv[k], 1'b0, '0, r0, r1);
            checks++;
            if (r0 !== rs[k] || r1 !== rev(rs[k])) begin
                failures++;
                $display("FAIL burst_miso[%0d]: got %h/%h expected %h/%h", k, r0, r1, rs[k], rev(rs[k]));
            end
        end
        cs_high();
        checks++;
        if (got0_q.size() != 3 || got1_q.size() != 3) begin
            failures++;
            $display("FAIL burst_count: got %0d/%0d expected 3/3", got0_q.size(), got1_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                t = wv[k];
                checks++;
                if (got0_q[k] !== {dv[k], t} || got1_q[k] !== {dv[k], rev(t)}) begin
                    failures++;
                    $display("FAIL burst_rx[%0d]: got %h/%h expected %h/%h", k, got0_q[k], got1_q[k], {dv[k], t}, {dv[k], rev(t)});
                end
            end
        end
        checks++;
        if (und0_cnt != 2 || und1_cnt != 2) begin
            failures++;
            $display("FAIL burst_underrun: got %0d/%0d expected 2/2", und0_cnt, und1_cnt);
        end
    endtask

    task automatic test_partial();
        logic [W-1:0] r0, r1;
        logic         m0, m1;
        clear_obs();
        cs_low();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b1, m0, m1);
        cs_high();
        checks++;
        if (got0_q.size() != 0 || got1_q.size() != 0) begin
            failures++;
            $display("FAIL partial_no_valid: got %0d/%0d words expected 0/0", got0_q.size(), got1_q.size());
        end
        checks++;
        if (rxd0 !== 8'h33 || rxd1 !== rev(8'h33)) begin
            failures++;
            $display("FAIL partial_rx_hold: got %h/%h expected 33/%h", rxd0, rxd1, rev(8'h33));
        end
        cs_low();
        xfer_word(8'h81, 1'b0, 1'b0, '0, r0, r1);
        cs_high();
        checks++;
        if (got0_q.size() != 1 || got0_q[0] !== {1'b0, 8'h81} || got1_q.size() != 1 || got1_q[0] !== {1'b0, rev(8'h81)}) begin
            failures++;
            $display("FAIL partial_next_rx: n=%0d/%0d got %h expected 081", got0_q.size(), got1_q.size(), got0_q.size() ? got0_q[0] : 9'h0);
        end
    endtask

    task automatic test_lsb_cpol1();
        logic [W-1:0] r0, r1;
        clear_obs();
        load_word(8'h01);
        cs_low();
        checks++;
        if (oe1 !== 1'b1 || miso1 !== 1'b1) begin
            failures++;
            $display("FAIL lsb_first_miso_bit: got oe=%b miso=%b expected 1 1", oe1, miso1);
        end
        // wire carries 1 first, then seven 0s
        xfer_word(8'h80, 1'b1, 1'b0, '0, r0, r1);
        cs_high();
        checks++;
        if (got1_q.size() != 1 || got1_q[0] !== {1'b1, 8'h01}) begin
            failures++;
            $display("FAIL lsb_rx1: n=%0d got %h expected 101", got1_q.size(), got1_q.size() ? got1_q[0] : 9'h0);
        end
        checks++;
        if (got0_q.size() != 1 || got0_q[0] !== {1'b1, 8'h80}) begin
            failures++;
            $display("FAIL lsb_rx0: n=%0d got %h expected 180", got0_q.size(), got0_q.size() ? got0_q[0] : 9'h0);
        end
        checks++;
        if (r1 !== 8'h80 || r0 !== 8'h01) begin
            failures++;
            $display("FAIL lsb_miso: got %h/%h expected 01/80", r0, r1);
        end
        checks++;
        if ({miso1, oe1, miso0, oe0} !== 4'b0000) begin
            failures++;
            $display("FAIL lsb_idle_miso: got %b expected 0000", {miso1, oe1, miso0, oe0});
        end
    endtask

    task automatic test_arst();
        logic [W-1:0] r0, r1;
        logic         m0, m1;
        clear_obs();
        cs_low();
        for (int i = 0; i < 4; i++) spi_bit(i[0], 1'b0, m0, m1);
        arst = 1'b1;
        #1;
        checks++;
        if (outs0 !== RST_OUTS || outs1 !== RST_OUTS) begin
            failures++;
            $display("FAIL arst_outs: got %h/%h expected %h", outs0, outs1, RST_OUTS);
        end
        @(negedge clk);
        ncs_pin = 1'b1;
        sclk0   = 1'b0;
        wait_clk(3);
        arst = 1'b0;
        wait_clk(6);
        checks++;
        if (got0_q.size() != 0 || got1_q.size() != 0 || st0 !== 1'b0 || st1 !== 1'b0) begin
            failures++;
            $display("FAIL arst_no_valid: got %0d/%0d words state %b%b expected 0/0 00", got0_q.size(), got1_q.size(), st0, st1);
        end
        cs_low();
        xfer_word(8'h7E, 1'b1, 1'b0, '0, r0, r1);
        cs_high();
        checks++;
        if (got0_q.size() != 1 || got0_q[0] !== {1'b1, 8'h7E} || got1_q.size() != 1 || got1_q[0] !== {1'b1, rev(8'h7E)}) begin
            failures++;
            $display("FAIL arst_next_rx: n=%0d/%0d got %h expected 17e", got0_q.size(), got1_q.size(), got0_q.size() ? got0_q[0] : 9'h0);
        end
        checks++;
        if (r0 !== 8'h00 || r1 !== 8'h00) begin
            failures++;
            $display("FAIL arst_miso: got %h/%h expected 00/00", r0, r1);
        end
    endtask

    task automatic test_ncs_race();
        logic m0, m1;
        clear_obs();
        cs_low();
        for (int i = 0; i < W - 1; i++) spi_bit(1'b1, 1'b0, m0, m1);
        sclk0 = 1'b0;
        mosi  = 1'b1;
        wait_clk(HALF);
        ncs_pin = 1'b1;
        sclk0   = 1'b1;
        wait_clk(4);
        sclk0 = 1'b0;
        mosi  = 1'b0;
        wait_clk(HALF + 2);
        checks++;
        if (got0_q.size() != 0 || got1_q.size() != 0) begin
            failures++;
            $display("FAIL race_no_valid: got %0d/%0d words expected 0/0", got0_q.size(), got1_q.size());
        end
        checks++;
        if (rxd0 !== 8'h7E || st0 !== 1'b0 || st1 !== 1'b0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL race_state: got rx=%h st=%b%b busy=%b expected 7e 00 0", rxd0, st0, st1, busy0);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] wv, lv, pv, r0, r1, t;
        logic         d, ld, pre;
        int           nw, exp_und;
        logic [W:0]   exp_q[$];
        logic [W-1:0] rsp_q[$];
        logic [W-1:0] rd0_q[$];
        logic [W-1:0] rd1_q[$];
        for (int it = 0; it < 16; it++) begin
            clear_obs();
            exp_q.delete();
            rsp_q.delete();
            rd0_q.delete();
            rd1_q.delete();
            exp_und = 0;
            nw  = $urandom_range(1, 4);
            pre = 1'($urandom_range(0, 1));
            pv  = W'($urandom);
            // word k answers with whatever was loaded before it started, else zero plus an underrun
            if (pre) begin
                load_word(pv);
                rsp_q.push_back(pv);
            end else begin
                rsp_q.push_back('0);
                exp_und++;
            end
            cs_low();
            for (int k = 0; k < nw; k++) begin
                wv = W'($urandom);
                d  = 1'($urandom_range(0, 1));
                ld = (k < nw - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                lv = W'($urandom);
                xfer_word(wv, d, ld, lv, r0, r1);
                exp_q.push_back({d, wv});
                rd0_q.push_back(r0);
                rd1_q.push_back(r1);
                if (k < nw - 1) begin
                    if (ld) rsp_q.push_back(lv);
                    else begin
                        rsp_q.push_back('0);
                        exp_und++;
                    end
                end
            end
            cs_high();
            checks++;
            if (got0_q.size() != nw || got1_q.size() != nw) begin
                failures++;
                $display("FAIL rand%0d_count: got %0d/%0d expected %0d", it, got0_q.size(), got1_q.size(), nw);
            end else begin
                for (int k = 0; k < nw; k++) begin
                    t = exp_q[k][W-1:0];
                    checks++;
                    if (got0_q[k] !== exp_q[k] || got1_q[k] !== {exp_q[k][W], rev(t)}) begin
                        failures++;
                        $display("FAIL rand%0d_rx[%0d]: got %h/%h expected %h/%h", it, k, got0_q[k], got1_q[k], exp_q[k], {exp_q[k][W], rev(t)});
                    end
                    checks++;
                    if (rd0_q[k] !== rsp_q[k] || rd1_q[k] !== rev(rsp_q[k])) begin
                        failures++;
                        $display("FAIL rand%0d_miso[%0d]: got %h/%h expected %h/%h", it, k, rd0_q[k], rd1_q[k], rsp_q[k], rev(rsp_q[k]));
                    end
                end
            end
            checks++;
            if (und0_cnt != exp_und || und1_cnt != exp_und) begin
                failures++;
                $display("FAIL rand%0d_underrun: got %0d/%0d expected %0d", it, und0_cnt, und1_cnt, exp_und);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_preload();
        test_burst();
        test_partial();
        test_lsb_cpol1();
        test_arst();
        test_ncs_race();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
